// File: rtl/bcd_counter_ndigit_pkg.sv
// Shared BCD constants and helpers for the multi-digit BCD counter.
package bcd_counter_ndigit_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

   // True when the nibble holds a legal decimal digit.
   function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_counter_ndigit_digit.sv
// One BCD decade: holds a digit 0..9, steps up or down when told, loads a sanitised digit.
module bcd_counter_ndigit_digit
   import bcd_counter_ndigit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               step,
   input  logic               up_dn,
   input  logic               load,
   input  logic [DIGIT_W-1:0] ld_digit,
   output logic [DIGIT_W-1:0] digit,
   output logic               at_max,
   output logic               at_min
);

   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_nxt;

   // Load wins over step; an out-of-range load digit becomes 0.
   always_comb begin
      digit_nxt = digit_q;
      if (load) begin
         digit_nxt = is_bcd(ld_digit) ? ld_digit : BCD_MIN;
      end else if (step) begin
         if (up_dn) begin
            digit_nxt = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + DIGIT_W'(1);
         end else begin
            digit_nxt = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= BCD_MIN;
      end else begin
         digit_q <= digit_nxt;
      end
   end

   assign digit  = digit_q;
   assign at_max = (digit_q == BCD_MAX);
   assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-decade synchronous BCD up/down counter with load, wrap/saturate, carry pulse and terminal count.
module bcd_counter_ndigit
   import bcd_counter_ndigit_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter bit          WRAP       = 1'b1
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          up_dn,
   input  logic                          load,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
   output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
   output logic                          carry_out,
   output logic                          tc,
   output logic                          load_err
);

   localparam int unsigned W = DIGIT_W * NUM_DIGITS;

   logic [NUM_DIGITS-1:0] at_max;
   logic [NUM_DIGITS-1:0] at_min;
   logic [NUM_DIGITS-1:0] step;
   logic                  all_max;
   logic                  all_min;
   logic                  limit_hit;
   logic                  count_ok;
   logic                  ld_bad;
   logic                  carry_q;
   logic                  load_err_q;

   assign all_max   = &at_max;
   assign all_min   = &at_min;
   assign limit_hit = up_dn ? all_max : all_min;

   // In saturate mode the counter refuses to step past the limit in the current direction.
   assign count_ok = en & ~load & (WRAP | ~limit_hit);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign step[gi] = count_ok;
         end else begin : g_upper
            assign step[gi] = step[gi-1] & (up_dn ? at_max[gi-1] : at_min[gi-1]);
         end

         bcd_counter_ndigit_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .step     (step[gi]),
            .up_dn    (up_dn),
            .load     (load),
            .ld_digit (load_val[gi*DIGIT_W +: DIGIT_W]),
            .digit    (bcd_out[gi*DIGIT_W +: DIGIT_W]),
            .at_max   (at_max[gi]),
            .at_min   (at_min[gi])
         );
      end
   endgenerate

   // Any non-decimal nibble in the load word.
   always_comb begin
      ld_bad = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (!is_bcd(load_val[i*DIGIT_W +: DIGIT_W])) begin
            ld_bad = 1'b1;
         end
      end
   end

   // Carry fires on the edge that wraps, so it lines up with the wrapped value.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q    <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         carry_q    <= count_ok & limit_hit;
         load_err_q <= load & ld_bad;
      end
   end

   assign carry_out = carry_q;
   assign load_err  = load_err_q;
   assign tc        = limit_hit;

   logic unused_w;
   assign unused_w = ^W;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench for the BCD counter: two-digit wrap and saturate instances plus a four-digit soak.
module tb_bcd_counter_ndigit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 2 digits, wrap
   logic a_rst, a_en, a_up, a_load, a_carry, a_tc, a_lerr;
   logic [7:0] a_ld, a_bcd;
   // Instance B: 2 digits, saturate
   logic b_rst, b_en, b_up, b_load, b_carry, b_tc, b_lerr;
   logic [7:0] b_ld, b_bcd;
   // Instance C: 4 digits, wrap
   logic c_rst, c_en, c_up, c_load, c_carry, c_tc, c_lerr;
   logic [15:0] c_ld, c_bcd;

   bcd_counter_ndigit #(.NUM_DIGITS(2), .WRAP(1'b1)) u_a (
      .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .load(a_load), .load_val(a_ld),
      .bcd_out(a_bcd), .carry_out(a_carry), .tc(a_tc), .load_err(a_lerr));

   bcd_counter_ndigit #(.NUM_DIGITS(2), .WRAP(1'b0)) u_b (
      .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .load(b_load), .load_val(b_ld),
      .bcd_out(b_bcd), .carry_out(b_carry), .tc(b_tc), .load_err(b_lerr));

   bcd_counter_ndigit #(.NUM_DIGITS(4), .WRAP(1'b1)) u_c (
      .clk(clk), .rst(c_rst), .en(c_en), .up_dn(c_up), .load(c_load), .load_val(c_ld),
      .bcd_out(c_bcd), .carry_out(c_carry), .tc(c_tc), .load_err(c_lerr));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   int  cnt, enabled, carries;
   logic exp_c, ok;

   initial begin
      a_rst = 1; a_en = 0; a_up = 0; a_load = 0; a_ld = '0;
      b_rst = 1; b_en = 0; b_up = 0; b_load = 0; b_ld = '0;
      c_rst = 1; c_en = 0; c_up = 1; c_load = 0; c_ld = '0;
      tick();

      // Reset state
      check("rst_bcd", 32'(a_bcd), 32'h00);
      check("rst_carry", 32'(a_carry), 0);
      check("rst_lerr", 32'(a_lerr), 0);
      check("rst_tc_down", 32'(a_tc), 1);
      a_up = 1; #1;
      check("rst_tc_up", 32'(a_tc), 0);

      // Test 1: reset mid-count
      a_rst = 0; a_load = 1; a_ld = 8'h47; tick();
      check("t1_load47", 32'(a_bcd), 32'h47);
      a_load = 0; a_en = 1; tick();
      check("t1_count48", 32'(a_bcd), 32'h48);
      a_rst = 1; tick();
      check("t1_rst_bcd", 32'(a_bcd), 32'h00);
      check("t1_rst_carry", 32'(a_carry), 0);
      check("t1_rst_lerr", 32'(a_lerr), 0);
      a_load = 1; a_ld = 8'hA3; tick();
      check("t1_rst_over_load", 32'(a_bcd), 32'h00);
      check("t1_rst_over_lerr", 32'(a_lerr), 0);
      a_rst = 0;

      // Test 2: load 08 then count up through a decade boundary
      a_en = 0; a_load = 1; a_ld = 8'h08; tick();
      check("t2_load08", 32'(a_bcd), 32'h08);
      a_load = 0; a_en = 1; a_up = 1;
      tick(); check("t2_09", 32'(a_bcd), 32'h09); check("t2_c09", 32'(a_carry), 0);
      tick(); check("t2_10", 32'(a_bcd), 32'h10); check("t2_c10", 32'(a_carry), 0);
      tick(); check("t2_11", 32'(a_bcd), 32'h11); check("t2_c11", 32'(a_carry), 0);

      // Test 3: wrap in both directions
      a_en = 0; a_load = 1; a_ld = 8'h98; tick();
      a_load = 0; a_en = 1;
      tick(); check("t3_99", 32'(a_bcd), 32'h99); check("t3_c99", 32'(a_carry), 0);
      check("t3_tc99", 32'(a_tc), 1);
      tick(); check("t3_00", 32'(a_bcd), 32'h00); check("t3_c00", 32'(a_carry), 1);
      tick(); check("t3_01", 32'(a_bcd), 32'h01); check("t3_c01", 32'(a_carry), 0);
      a_en = 0; a_load = 1; a_ld = 8'h00; tick();
      check("t3_ld_c", 32'(a_carry), 0);
      a_load = 0; a_en = 1; a_up = 0;
      tick(); check("t3_dn99", 32'(a_bcd), 32'h99); check("t3_dn_c99", 32'(a_carry), 1);
      tick(); check("t3_dn98", 32'(a_bcd), 32'h98); check("t3_dn_c98", 32'(a_carry), 0);
      a_up = 1;
      tick(); check("t3_dir99", 32'(a_bcd), 32'h99); check("t3_dir_c", 32'(a_carry), 0);

      // Test 5: load sanitising, load priority over en
      a_en = 0; a_load = 1; a_ld = 8'hA7; tick();
      check("t5_A7", 32'(a_bcd), 32'h07); check("t5_lerr", 32'(a_lerr), 1);
      a_load = 0; tick();
      check("t5_hold", 32'(a_bcd), 32'h07); check("t5_lerr_off", 32'(a_lerr), 0);
      check("t5_hold_c", 32'(a_carry), 0);
      a_en = 1; a_load = 1; a_ld = 8'h3F; tick();
      check("t5_3F", 32'(a_bcd), 32'h30); check("t5_lerr2", 32'(a_lerr), 1);
      a_ld = 8'h99; tick();
      check("t5_ld99", 32'(a_bcd), 32'h99); check("t5_ld99_lerr", 32'(a_lerr), 0);
      tick();
      check("t5_ld_at_max", 32'(a_bcd), 32'h99); check("t5_ld_no_carry", 32'(a_carry), 0);
      a_load = 0; a_en = 0;

      // Test 4: saturate instance
      b_rst = 0; b_load = 1; b_ld = 8'h99; tick();
      b_load = 0; b_en = 1; b_up = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_sat99", 32'(b_bcd), 32'h99);
         check("t4_sat_c", 32'(b_carry), 0);
         check("t4_sat_tc", 32'(b_tc), 1);
      end
      b_up = 0; tick(); check("t4_98", 32'(b_bcd), 32'h98);
      b_en = 0; b_load = 1; b_ld = 8'h00; tick();
      b_load = 0; b_en = 1;
      tick(); check("t4_sat00", 32'(b_bcd), 32'h00); check("t4_sat00_c", 32'(b_carry), 0);
      b_up = 1; tick(); check("t4_01", 32'(b_bcd), 32'h01);
      b_en = 0;

      // Test 6: four digits, 10000 enabled steps with random gaps
      c_rst = 0; cnt = 0; enabled = 0; carries = 0;
      while (enabled < 10000) begin
         c_en = ($urandom_range(0, 3) != 0);
         tick();
         exp_c = 1'b0;
         if (c_en) begin
            cnt = (cnt + 1) % 10000;
            enabled++;
            exp_c = (cnt == 0);
         end
         check("t6_val", 32'(c_bcd), to_bcd(cnt));
         check("t6_carry", 32'(c_carry), 32'(exp_c));
         if (c_carry) carries++;
         ok = 1'b1;
         for (int j = 0; j < 4; j++) if (c_bcd[j*4 +: 4] > 4'd9) ok = 1'b0;
         check("t6_digits", 32'(ok), 1);
      end
      check("t6_one_carry", 32'(carries), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
